// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the RV32I instruction fetch stage:
//   - INST_WIDTH             : instruction word width
//   - DEFAULT_RESET_VECTOR   : default PC after reset
//   - NOP_INSTRUCTION        : addi x0,x0,0, shown to ID in empty slots
//   - fetch_state_e          : fetch sequencer states
//   - align_pc()             : forces a target address onto a word boundary
// -----------------------------------------------------------------------------
package if_stage_pkg;

  localparam int INST_WIDTH = 32;

  localparam logic [31:0]           DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [INST_WIDTH-1:0] NOP_INSTRUCTION      = 32'h0000_0013;

  // IDLE : first cycle after reset release
  // REQ  : presenting a request (when the skid buffer is empty)
  // WAIT : one request outstanding, its response will be delivered
  // DROP : one request outstanding, its response will be discarded
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register: valid flag, instruction and its PC.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   flush             : invalidate the slot (highest priority)
//   load              : capture inst_in/pc_in as a valid instruction
//   hold              : keep current contents (ID is stalled)
//   inst_in, pc_in    : incoming instruction and PC
//   valid             : slot holds a real instruction
//   instruction       : instruction to the decoder (NOP_INST when !valid)
//   pc                : PC of instruction
// When neither load nor hold is asserted, ID has consumed the slot and it
// becomes a bubble. The PC field is left alone on flush/bubble.
// -----------------------------------------------------------------------------
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0]           RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [INST_WIDTH-1:0] NOP_INST     = NOP_INSTRUCTION
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  hold,
  input  logic [INST_WIDTH-1:0] inst_in,
  input  logic [31:0]           pc_in,
  output logic                  valid,
  output logic [INST_WIDTH-1:0] instruction,
  output logic [31:0]           pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid       <= 1'b0;
      instruction <= NOP_INST;
      pc          <= RESET_VECTOR;
    end else if (flush) begin
      valid       <= 1'b0;
      instruction <= NOP_INST;
    end else if (load) begin
      valid       <= 1'b1;
      instruction <= inst_in;
      pc          <= pc_in;
    end else if (!hold) begin
      // Slot consumed by ID with nothing new to offer: insert a bubble.
      valid       <= 1'b0;
      instruction <= NOP_INST;
    end
  end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// RV32I instruction fetch stage. Owns the PC, runs a single-outstanding
// request/response handshake to instruction memory and feeds the IF/ID
// register. A one-entry skid buffer catches a response that arrives while ID
// is stalled on a valid instruction.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   imem_req_valid/ready: fetch request handshake
//   imem_addr           : word-aligned fetch address (current PC)
//   imem_rsp_valid/data : one response per accepted request
//   id_stall            : hold IF/ID contents
//   redirect_valid/pc   : flush and restart fetch at redirect_pc
//   if_id_valid/instruction/pc : IF/ID register outputs
// -----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0]           RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [INST_WIDTH-1:0] NOP_INST     = NOP_INSTRUCTION
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [31:0]           imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  id_stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  if_id_valid,
  output logic [INST_WIDTH-1:0] if_id_instruction,
  output logic [31:0]           if_id_pc
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next;

  logic                  buf_valid, buf_valid_next;
  logic [INST_WIDTH-1:0] buf_inst;
  logic [31:0]           buf_pc;

  logic                  req_fire;
  logic                  deliver;
  logic                  slot_open;
  logic                  buf_load;
  logic                  buf_drain;
  logic                  slot_load;
  logic [31:0]           rsp_pc;
  logic [INST_WIDTH-1:0] slot_inst;
  logic [31:0]           slot_pc;

  // No new request while the buffer is occupied: at most one instruction can
  // be parked outside IF/ID.
  assign imem_req_valid = (state == ST_REQ) && !buf_valid;
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // In WAIT the PC has already advanced past the outstanding request and can
  // only move again by redirect, which discards the response, so pc-4 is the
  // address the response belongs to.
  assign rsp_pc    = pc - 32'd4;
  assign deliver   = (state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
  assign slot_open = !id_stall || !if_id_valid;
  assign buf_load  = deliver && !slot_open;
  // The buffer is only full in REQ, so draining never collides with a delivery.
  assign buf_drain = buf_valid && !id_stall && !redirect_valid;
  assign slot_load = (deliver && slot_open) || buf_drain;
  assign slot_inst = buf_drain ? buf_inst : imem_rsp_data;
  assign slot_pc   = buf_drain ? buf_pc   : rsp_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_VECTOR;
      buf_valid <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      buf_valid <= buf_valid_next;
    end
  end

  // Buffer payload is qualified by buf_valid and needs no reset.
  always_ff @(posedge clk) begin
    if (buf_load) begin
      buf_inst <= imem_rsp_data;
      buf_pc   <= rsp_pc;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    buf_valid_next = buf_valid;

    if (redirect_valid) begin
      pc_next        = align_pc(redirect_pc);
      buf_valid_next = 1'b0;
      case (state)
        ST_IDLE: state_next = ST_REQ;
        // A request accepted in this same cycle still owes us a response.
        ST_REQ:  state_next = req_fire ? ST_DROP : ST_REQ;
        ST_WAIT: state_next = imem_rsp_valid ? ST_REQ : ST_DROP;
        ST_DROP: state_next = imem_rsp_valid ? ST_REQ : ST_DROP;
        default: state_next = ST_IDLE;
      endcase
    end else begin
      if (buf_load) begin
        buf_valid_next = 1'b1;
      end else if (buf_drain) begin
        buf_valid_next = 1'b0;
      end

      case (state)
        ST_IDLE: state_next = ST_REQ;
        ST_REQ: begin
          if (req_fire) begin
            pc_next    = pc + 32'd4;
            state_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            state_next = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_rsp_valid) begin
            state_next = ST_REQ;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  if_id_reg #(
    .RESET_VECTOR (RESET_VECTOR),
    .NOP_INST     (NOP_INST)
  ) u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (redirect_valid),
    .load        (slot_load),
    .hold        (id_stall),
    .inst_in     (slot_inst),
    .pc_in       (slot_pc),
    .valid       (if_id_valid),
    .instruction (if_id_instruction),
    .pc          (if_id_pc)
  );

endmodule
